// File: rtl/contadores_param.sv
// contadores_param
//   Per-channel pop counters for the transaction layer. Each channel counts
//   accepted pops (pop=1 while the FIFO is not empty) in a saturating counter
//   with a sticky overflow flag. While the datapath is idle, a read request
//   returns either one indexed channel (SINGLE) or all channels in order
//   (SWEEP), one {ovf, count} word per cycle on data/valid.
//
//   Optional feature macro: CONTADORES_CLR_ON_READ_EN
//     defined   : every launched word clears that channel's count and ovf at
//                 the launch edge (a pop in that same cycle leaves count=1).
//     undefined : reads are non-destructive; counters clear only on rst.
//
//   Handshake: req is sampled on every rising edge and is only accepted when
//   idle=1 and the FSM is in WAIT or SINGLE. There is no backpressure; data is
//   meaningful exactly in the cycles where valid=1, one word per cycle, and
//   busy=1 marks the cycles that belong to a sweep.
//
//   dbg_state / dbg_idx expose the FSM state and latched index for checkers.

module contadores_param #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 5,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] pop,
    input  logic [NUM_CH-1:0] empty,
    input  logic              idle,
    input  logic              req,
    input  logic              sweep,
    input  logic [IDX_W-1:0]  idx,
    output logic [CNT_W:0]    data,
    output logic              valid,
    output logic              busy,
    output logic [1:0]        dbg_state,
    output logic [IDX_W-1:0]  dbg_idx
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SINGLE = 2'd1,
        S_SWEEP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   idx_q;

    logic [CNT_W-1:0]   count [NUM_CH];
    logic [NUM_CH-1:0]  ovf;

    logic               start_ok;
    logic               launch;
    logic [IDX_W-1:0]   launch_ch;
    logic [CNT_W:0]     word;
    logic [NUM_CH-1:0]  pop_ok;
    logic [NUM_CH-1:0]  clr;

    // A new read may start from WAIT, or straight out of SINGLE with no bubble.
    always_comb begin
        start_ok = req && idle && ((state == S_WAIT) || (state == S_SINGLE));
    end

    // Pick the channel whose word is launched at the coming edge, if any.
    always_comb begin
        launch    = 1'b0;
        launch_ch = '0;
        if (start_ok) begin
            launch    = 1'b1;
            launch_ch = sweep ? '0 : idx;
        end else if ((state == S_SWEEP) && (ptr != LAST_CH)) begin
            launch    = 1'b1;
            launch_ch = ptr + IDX_W'(1);
        end
    end

    // Word mux over the registered counters; an out-of-range channel matches
    // nothing, so it yields zero and clears nothing.
    always_comb begin
        word = '0;
        clr  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (launch && (launch_ch == IDX_W'(i))) begin
                word = {ovf[i], count[i]};
`ifdef CONTADORES_CLR_ON_READ_EN
                clr[i] = 1'b1;
`endif
            end
        end
    end

    // A pop is only real when the FIFO actually has data.
    always_comb begin
        pop_ok = pop & ~empty;
    end

    // Saturating per-channel counters with sticky overflow; run in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr[i]) begin
                    count[i] <= pop_ok[i] ? CNT_W'(1) : '0;
                    ovf[i]   <= 1'b0;
                end else if (pop_ok[i]) begin
                    if (count[i] == CNT_MAX) begin
                        ovf[i] <= 1'b1;
                    end else begin
                        count[i] <= count[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Read FSM with registered data/valid/busy; data captures the counter
    // value from before any pop at the launch edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WAIT;
            ptr   <= '0;
            idx_q <= '0;
            data  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_SWEEP: begin
                    if (ptr == LAST_CH) begin
                        state <= S_WAIT;
                        data  <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        ptr   <= ptr + IDX_W'(1);
                        data  <= word;
                        valid <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    // WAIT and SINGLE behave the same: accept a new request or
                    // drop back to WAIT.
                    if (start_ok) begin
                        if (sweep) begin
                            state <= S_SWEEP;
                            ptr   <= '0;
                            busy  <= 1'b1;
                        end else begin
                            state <= S_SINGLE;
                            idx_q <= idx;
                            busy  <= 1'b0;
                        end
                        data  <= word;
                        valid <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                        data  <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign dbg_state = state;
    assign dbg_idx   = idx_q;

endmodule

// File: tb/tb_contadores_param.sv
// Bench for contadores_param (NUM_CH=4, CNT_W=5). Inputs are applied after
// the rising edge, outputs are checked 1 time unit after the next rising edge.
module tb_contadores_param;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 5;
  localparam int IDX_W  = 2;

`ifdef CONTADORES_CLR_ON_READ_EN
  localparam logic [5:0] EXP_SAT_AGAIN = 6'd0;
  localparam logic [5:0] EXP_POP_AGAIN = 6'd1;
`else
  localparam logic [5:0] EXP_SAT_AGAIN = 6'h3F;
  localparam logic [5:0] EXP_POP_AGAIN = 6'd10;
`endif

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] empty;
  logic              idle;
  logic              req;
  logic              sweep;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W:0]    data;
  logic              valid;
  logic              busy;
  logic [1:0]        dbg_state;
  logic [IDX_W-1:0]  dbg_idx;

  contadores_param #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pop       (pop),
    .empty     (empty),
    .idle      (idle),
    .req       (req),
    .sweep     (sweep),
    .idx       (idx),
    .data      (data),
    .valid     (valid),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_idx   (dbg_idx)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] pop;
    logic [3:0] empty;
    logic       idle;
    logic       req;
    logic       sweep;
    logic [1:0] idx;
    logic       exp_valid;
    logic       exp_busy;
    logic [5:0] exp_data;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];   // {valid, busy, data}
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic vec_t mk(input string nm, input logic r, input logic [3:0] p,
                              input logic [3:0] e, input logic il, input logic rq,
                              input logic sw, input logic [1:0] ix, input logic ev,
                              input logic eb, input logic [5:0] ed);
    vec_t v;
    v.name = nm; v.rst = r; v.pop = p; v.empty = e; v.idle = il; v.req = rq;
    v.sweep = sw; v.idx = ix; v.exp_valid = ev; v.exp_busy = eb; v.exp_data = ed;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(input string nm, input string what, input logic [7:0] act,
                       input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h at %0t", nm, what, act, exp, $time);
    end
  endtask

  // driver: one vector per clock cycle
  task automatic apply(input vec_t v);
    logic [7:0] e;
    rst = v.rst; pop = v.pop; empty = v.empty; idle = v.idle;
    req = v.req; sweep = v.sweep; idx = v.idx;
    exp_q.push_back({v.exp_valid, v.exp_busy, v.exp_data});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(v.name, "valid", {7'd0, valid}, {7'd0, e[7]});
    check(v.name, "busy", {7'd0, busy}, {7'd0, e[6]});
    if (e[7] || v.rst) check(v.name, "data", {2'd0, data}, {2'd0, e[5:0]});
  endtask

  task automatic run(input string nm, input logic r, input logic [3:0] p,
                     input logic [3:0] e, input logic il, input logic rq,
                     input logic sw, input logic [1:0] ix, input logic ev,
                     input logic eb, input logic [5:0] ed);
    apply(mk(nm, r, p, e, il, rq, sw, ix, ev, eb, ed));
  endtask

  initial begin
    rst = 1'b1; pop = '0; empty = '0; idle = 1'b0; req = 1'b0; sweep = 1'b0; idx = '0;

    // ---- vector table ----
    // reset, then a sweep of all-zero counters
    vecs.push_back(mk("reset", 1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 6'd0));
    vecs.push_back(mk("reset", 1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 6'd0));
    vecs.push_back(mk("sweep_w0", 0, 4'h0, 4'h0, 1, 1, 1, 0, 1, 1, 6'd0));
    vecs.push_back(mk("sweep_w1", 0, 4'h0, 4'h0, 1, 0, 0, 0, 1, 1, 6'd0));
    vecs.push_back(mk("sweep_w2", 0, 4'h0, 4'h0, 1, 0, 0, 0, 1, 1, 6'd0));
    vecs.push_back(mk("sweep_w3", 0, 4'h0, 4'h0, 1, 0, 0, 0, 1, 1, 6'd0));
    vecs.push_back(mk("sweep_end", 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0));
    // three real pops on FIFO0, one pop while empty
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk("pop0", 0, 4'b0001, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0));
    vecs.push_back(mk("pop0_empty", 0, 4'b0001, 4'b0001, 1, 0, 0, 0, 0, 0, 6'd0));
    vecs.push_back(mk("read0", 0, 4'h0, 4'h0, 1, 1, 0, 0, 1, 0, 6'd3));
    vecs.push_back(mk("read0_end", 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0));
    // FIFO1 to 7, FIFO2 to 2; requests while not idle are dropped
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk("pop12", 0, {1'b0, (k < 2), 1'b1, 1'b0}, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk("req_not_idle", 0, 4'h0, 4'h0, 0, 1, k[0], 1, 0, 0, 6'd0));
    vecs.push_back(mk("read1", 0, 4'h0, 4'h0, 1, 1, 0, 1, 1, 0, 6'd7));
    vecs.push_back(mk("read2_b2b", 0, 4'h0, 4'h0, 1, 1, 0, 2, 1, 0, 6'd2));
    vecs.push_back(mk("read_end", 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0));

    foreach (vecs[i]) apply(vecs[i]);

    // ---- saturation and sticky overflow on FIFO2 ----
    for (int k = 0; k < 35; k++) run("pop2", 0, 4'b0100, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0);
    run("read2_sat", 0, 4'h0, 4'h0, 1, 1, 0, 2, 1, 0, 6'h3F);
    run("gap2", 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0);
    run("read2_again", 0, 4'h0, 4'h0, 1, 1, 0, 2, 1, 0, EXP_SAT_AGAIN);
    run("gap2b", 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0);

    // ---- reset in the middle of a sweep ----
    run("rst5", 1, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0);
    for (int k = 0; k < 7; k++)
      run("pop_4567", 0, {(k < 7), (k < 6), (k < 5), (k < 4)}, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0);
    run("sw5_w0", 0, 4'h0, 4'h0, 1, 1, 1, 0, 1, 1, 6'd4);
    run("sw5_w1", 0, 4'h0, 4'h0, 1, 1, 0, 3, 1, 1, 6'd5);
    run("sw5_rst", 1, 4'hF, 4'h0, 1, 1, 1, 0, 0, 0, 6'd0);
    run("after_rst", 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0);
    run("sw5z_w0", 0, 4'h0, 4'h0, 1, 1, 1, 0, 1, 1, 6'd0);
    run("sw5z_w1", 0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 1, 6'd0);
    run("sw5z_w2", 0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 1, 6'd0);
    run("sw5z_w3", 0, 4'h0, 4'h0, 1, 0, 0, 0, 1, 1, 6'd0);
    run("sw5z_end", 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0);

    // ---- pop and read of the same channel in the same cycle ----
    for (int k = 0; k < 9; k++) run("pop3", 0, 4'b1000, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0);
    run("read3_pop", 0, 4'b1000, 4'h0, 1, 1, 0, 3, 1, 0, 6'd9);
    run("gap3", 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0);
    run("read3_again", 0, 4'h0, 4'h0, 1, 1, 0, 3, 1, 0, EXP_POP_AGAIN);
    run("gap3b", 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 6'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/contadores_param.md
# contadores_param

Parametrised per-channel pop counter for the transaction layer, successor to the fixed 4-channel counter block. Counts accepted pops on each output FIFO. When the datapath reports idle, it returns counts to the testbench or host on request, either one indexed channel or a sweep of all channels. Each channel has a saturating counter with a sticky overflow flag.

## Interface
- NUM_CH, 4: number of FIFO channels; must be ≥2.
- CNT_W, 5: counter width in bits. Data output width is CNT_W+1.
- IDX_W, $clog2(NUM_CH): width of idx.

- clk  in  1  single clock; everything on rising edge.
- rst  in  1  synchronous, active-high reset.
- pop  in  NUM_CH  pop strobe per FIFO; bit i is FIFO i.
- empty  in  NUM_CH  empty flag per FIFO.
- idle  in  1  datapath idle; reads are accepted only when high.
- req  in  1  read request, sampled each cycle.
- sweep  in  1  sampled with req: 1 = read all channels, 0 = read channel idx.
- idx  in  IDX_W  channel to read in single mode.
- data  out  CNT_W+1  {ovf[ch], count[ch]}.
- valid  out  1  data qualifier, one cycle per word.
- busy  out  1  high while a sweep is in progress.

## Operation
- Counting: count[i] increments at the edge where pop[i]=1 and empty[i]=0.
  - A pop on an empty FIFO is ignored.
  - All channels count independently every cycle, in every FSM state.
- Saturation: count[i] holds at 2^CNT_W−1. The first pop at that value sets ovf[i]=1, and ovf[i] stays set until reset or a clear.
- FSM states:
  - WAIT: valid=0, busy=0.
    - req=1, idle=1, sweep=0: go to SINGLE and latch idx.
    - req=1, idle=1, sweep=1: go to SWEEP with ptr=0.
    - req=1 with idle=0: ignored; no response and no queuing.
  - SINGLE: one-cycle state. Drive data={ovf[idx_q],count[idx_q]} and valid=1.
    - If req=1 and idle=1 again, start the next read directly (SINGLE or SWEEP) with no bubble.
    - Otherwise return to WAIT.
  - SWEEP: drive data for channel ptr, valid=1, busy=1, then ptr++.
    - After ptr=NUM_CH−1, go to WAIT.
    - req, sweep and idx are ignored during SWEEP.
    - idle falling during SWEEP does not abort the sweep.
- Read value: the count as registered at the edge the word is launched, i.e. before any pop in that same cycle.
- Out-of-range idx (idx ≥ NUM_CH): data=0, valid=1.
- Reset: rst=1 at an edge does all of the following, even mid-SINGLE or mid-SWEEP:
  - clears all count, ovf, ptr and idx_q;
  - sets FSM=WAIT;
  - sets valid=0, busy=0, data=0;
  - ignores pop and req that cycle.

## Timing
- Reset values: data=0, valid=0, busy=0, all counters and flags 0.
- Count update: registered; count[i] is visible one cycle after the pop edge.
- Single read: req sampled at edge t, so data/valid are registered outputs valid from t to t+1 (1-cycle latency).
- Back-to-back single reads: req held high with idle=1 gives one word per cycle.
- Sweep: req+sweep at edge t gives valid high for exactly NUM_CH consecutive cycles starting after t. busy is high for the same cycles.
- Pop and read of the same channel in the same cycle: the reported value excludes that pop, and the counter still increments.

## Configuration
- Macro: CONTADORES_CLR_ON_READ_EN.
- Defined: each word launched clears that channel's count and ovf at the same edge.
  - A pop in that same cycle leaves count=1 (the pop is not lost).
  - An out-of-range idx clears nothing.
- Undefined: reads are non-destructive; counters clear only on rst.

## Test plan
All scenarios use NUM_CH=4, CNT_W=5.
1. rst for 2 cycles, then req=1, idle=1, sweep=1 → 4 words, each data=6'h00, valid high 4 cycles, busy high 4 cycles.
2. Pops on FIFO0 with empty=0 for 3 cycles, 1 further pop with empty0=1, then read idx=0 → data=6'd3.
3. 35 valid pops on FIFO2, read idx=2 → data={1'b1,5'd31}.
   - With CONTADORES_CLR_ON_READ_EN, a second read returns 6'd0.
   - Without it, the second read returns {1'b1,5'd31} again.
4. req=1 with idle=0 for 5 cycles → valid stays 0. Then raise idle with req=1, idx=1 (count 7) → data=6'd7 one cycle later.
5. Start a sweep with counts {4,5,6,7}, then assert rst at the 3rd word → at most 2 valid words {4,5}. Next cycle: valid=0, busy=0, and a new sweep returns all zeros.
6. Pop FIFO3 in the same cycle a single read of idx=3 (count 9) is launched → data=6'd9, and a following read gives 6'd10 (or 6'd1 with CONTADORES_CLR_ON_READ_EN).
